array_mult_seq: RTL
===================

Name: array_mult_seq

Overview:
- Parametrised successor to the team's 8x8 combinational array multiplier: an iterative radix-2 shift-add multiplier of configurable operand width.
- Adds a per-operation signed/unsigned mode, a full-width 2*WIDTH product, and valid/ready handshakes on both input and output.
- Intended as the multiply engine behind a tiny-tapeout style top, driven from the dedicated input and bidirectional pins through a thin wrapper.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  clock enable; when low all state holds.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  product p is valid.
- out_ready  input  1  consumer takes p.
- p  output  2*WIDTH  product.
- busy  output  1  high while in the CALC state.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; in_ready = 0 during reset, 1 on the first edge after release with ena = 1.
  - out_valid = 0, p = 0, busy = 0, iteration counter = 0, accumulator = 0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = ena.
  - Accept on an edge with in_valid & in_ready. At acceptance, register:
    - |a| and |b| (magnitude if signed_mode and the MSB is set, otherwise the raw value);
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator, set count = 0, go to CALC.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits.
- CALC: one iteration per enabled edge.
  - If multiplier bit[count] = 1, add |a| << count into the 2*WIDTH accumulator.
  - count increments. After iteration WIDTH-1:
    - p = neg ? -acc : acc (two's complement, 2*WIDTH bits);
    - go to DONE.
  - in_ready = 0; busy = 1.
- DONE:
  - out_valid = 1; p held stable.
  - On an edge with out_ready = 1 (and ena = 1): out_valid clears, go to IDLE.
  - No back-to-back accept in the same cycle as the output handshake.
  - in_ready = 0 in DONE.
- Latency: accept at edge k, out_valid high after edge k+WIDTH, i.e. WIDTH cycles. Throughput is one result per WIDTH+2 cycles with out_ready tied high.
- ena = 0: state, counter, accumulator and p freeze.
  - in_ready forced 0.
  - out_valid holds its value, but no handshake completes while ena = 0.
- Handshake rules:
  - a, b and signed_mode are sampled only at the accept edge; later changes are ignored.
  - out_ready held low leaves p and out_valid stable indefinitely.
- Arithmetic:
  - Unsigned result range 0..(2^WIDTH-1)^2.
  - Signed result is the exact product; -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable.
  - No overflow flag is needed.
- p is not cleared on the output handshake; it retains the last product until the next DONE.

Decomposition:
- Package mult_pkg:
  - state typedef (IDLE/CALC/DONE);
  - localparam DEFAULT_WIDTH = 8;
  - function for the counter width, clog2(WIDTH).
- Sub-module mult_sign_prep (combinational):
  - inputs a, b, signed_mode;
  - outputs mag_a, mag_b, neg;
  - instantiated once at the accept path.
- The FSM, counter and accumulator live in array_mult_seq.

Test Plan (WIDTH = 8):
- Unsigned corner: a = 0xFF, b = 0xFF, signed_mode = 0, out_ready = 1 -> out_valid exactly 8 cycles after accept, p = 0xFE01; then in_ready returns high.
- Signed mix: a = 0xFD (-3), b = 0x05, signed_mode = 1 -> p = 0xFFF1 (-15); same operands with signed_mode = 0 -> p = 0x04F1 (1265).
- Signed extreme: a = 0x80, b = 0x80, signed_mode = 1 -> p = 0x4000; a = 0x80, b = 0x7F -> p = 0xC080 (-16256).
- Backpressure and stability: complete 0x12 * 0x34 with out_ready = 0 for 20 cycles -> p = 0x03A8 held, out_valid held, in_ready = 0; in_valid pulsed with new operands during the stall is not accepted; releasing out_ready completes the handshake.
- ena gating: drop ena for 5 cycles at iteration 3 of 0x0A * 0x0B -> latency extends by exactly 5 cycles, p = 0x006E.
- Reset mid-CALC: assert rst asynchronously (between edges) during iteration 4 -> out_valid, busy, p drop to 0 immediately; the next accepted 0x02 * 0x03 gives p = 0x0006 with no residue from the aborted operation.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Iteration counter width: must index bits 0..WIDTH-1 of the multiplier.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_sign_prep.sv
// Converts operands to magnitudes and derives the result sign at the accept path.
module mult_sign_prep
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg
);

  logic a_neg;
  logic b_neg;

  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  assign mag_a = a_neg ? (~a + WIDTH'(1)) : a;
  assign mag_b = b_neg ? (~b + WIDTH'(1)) : b;
  assign neg   = a_neg ^ b_neg;

endmodule

// File: rtl/array_mult_seq.sv
// Iterative radix-2 shift-add multiplier with signed/unsigned mode and valid/ready handshakes.
module array_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] prep_mag_a;
  logic [WIDTH-1:0] prep_mag_b;
  logic             prep_neg;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;

  mult_sign_prep #(.WIDTH(WIDTH)) u_sign_prep (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .mag_a       (prep_mag_a),
    .mag_b       (prep_mag_b),
    .neg         (prep_neg)
  );

  // Ready is registered but still dropped immediately when the clock enable falls.
  assign in_ready  = ready_q & ena;
  assign out_valid = valid_q;
  assign p         = p_q;
  assign busy      = busy_q;

  assign addend = mag_b_q[count_q] ? (PW'(mag_a_q) << count_q) : '0;
  assign sum    = acc_q + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    p_d     = p_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    ready_d = ready_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (in_valid && in_ready) begin
            mag_a_d = prep_mag_a;
            mag_b_d = prep_mag_b;
            neg_d   = prep_neg;
            acc_d   = '0;
            count_d = '0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d   = sum;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            p_d     = neg_q ? (~sum + PW'(1)) : sum;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; a new accept needs a further edge.
          if (out_ready) begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          ready_d = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
